// File: rtl/io_output_ctrl_pkg.sv
// Shared io address map, status layout and handshake encodings for the output-port block.
package io_output_ctrl_pkg;

  localparam int IO_WIDTH = 32;

  // Output side lives at 0x80..0x8C; the input side uses 0xC0/0xC4.
  localparam logic [5:0] SEL_PORT0 = 6'b100000;
  localparam logic [5:0] SEL_PORT1 = 6'b100001;
  localparam logic [5:0] SEL_PORT2 = 6'b100010;
  localparam logic [5:0] SEL_STAT  = 6'b100011;

  localparam int VALID_LSB = 0;
  localparam int OVR_LSB   = 3;

  localparam logic [0:0] HS_IDLE    = 1'b0;
  localparam logic [0:0] HS_PENDING = 1'b1;

  function automatic logic [IO_WIDTH-1:0] status_word(input logic [2:0] ovr,
                                                      input logic [2:0] valid);
    logic [IO_WIDTH-1:0] w;
    w = {IO_WIDTH{1'b0}};
    w[OVR_LSB +: 3]   = ovr;
    w[VALID_LSB +: 3] = valid;
    return w;
  endfunction

endpackage

// File: rtl/io_output_ctrl_out_port.sv
// One output port: data register, valid/ack handshake and sticky overrun flag.
module io_out_port
  import io_output_ctrl_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_i,
  input  logic             clr_ovr_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             ovr_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             ovr_d, ovr_q;
  logic             set_ovr_s;

  // An ack arriving with the write consumes the old data, so it is not an overrun.
  assign set_ovr_s = wr_i & valid_q & ~ack_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (valid_q)
      HS_IDLE: begin
        if (wr_i) begin
          data_d  = din_i;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      HS_PENDING: begin
        if (wr_i) begin
          data_d  = din_i;
          valid_d = 1'b1;
        end else if (ack_i) begin
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase

    // A new overrun beats a simultaneous clear.
    if (set_ovr_s) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout_o  = data_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/io_output_ctrl.sv
// Memory-mapped output-port block: three handshaked store ports plus a status register,
// with a combinational readback mux on addr[7:2].
module io_output_ctrl #(
  parameter int         WIDTH     = io_output_ctrl_pkg::IO_WIDTH,
  parameter logic [5:0] SEL_PORT0 = io_output_ctrl_pkg::SEL_PORT0,
  parameter logic [5:0] SEL_PORT1 = io_output_ctrl_pkg::SEL_PORT1,
  parameter logic [5:0] SEL_PORT2 = io_output_ctrl_pkg::SEL_PORT2,
  parameter logic [5:0] SEL_STAT  = io_output_ctrl_pkg::SEL_STAT
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [WIDTH-1:0] datain,
  input  logic             write_io_enable,
  output logic [WIDTH-1:0] out_port0,
  output logic [WIDTH-1:0] out_port1,
  output logic [WIDTH-1:0] out_port2,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ack,
  output logic [WIDTH-1:0] io_read_data
);

  import io_output_ctrl_pkg::*;

  logic [5:0]       sel_s;
  logic [2:0]       wr_s;
  logic             stat_wr_s;
  logic [2:0]       clr_ovr_s;
  logic [2:0]       ovr_s;
  logic [WIDTH-1:0] stat_s;
  logic             unused_addr_s;

  assign sel_s         = addr[7:2];
  assign unused_addr_s = ^{addr[31:8], addr[1:0]};

  assign wr_s[0]   = write_io_enable & (sel_s == SEL_PORT0);
  assign wr_s[1]   = write_io_enable & (sel_s == SEL_PORT1);
  assign wr_s[2]   = write_io_enable & (sel_s == SEL_PORT2);
  assign stat_wr_s = write_io_enable & (sel_s == SEL_STAT);
  assign clr_ovr_s = {3{stat_wr_s}} & datain[OVR_LSB +: 3];

  io_out_port #(.WIDTH(WIDTH)) u_port0 (
    .clk_i(io_clk), .reset_i(reset), .wr_i(wr_s[0]), .clr_ovr_i(clr_ovr_s[0]),
    .ack_i(out_ack[0]), .din_i(datain), .dout_o(out_port0),
    .valid_o(out_valid[0]), .ovr_o(ovr_s[0])
  );

  io_out_port #(.WIDTH(WIDTH)) u_port1 (
    .clk_i(io_clk), .reset_i(reset), .wr_i(wr_s[1]), .clr_ovr_i(clr_ovr_s[1]),
    .ack_i(out_ack[1]), .din_i(datain), .dout_o(out_port1),
    .valid_o(out_valid[1]), .ovr_o(ovr_s[1])
  );

  io_out_port #(.WIDTH(WIDTH)) u_port2 (
    .clk_i(io_clk), .reset_i(reset), .wr_i(wr_s[2]), .clr_ovr_i(clr_ovr_s[2]),
    .ack_i(out_ack[2]), .din_i(datain), .dout_o(out_port2),
    .valid_o(out_valid[2]), .ovr_o(ovr_s[2])
  );

  assign stat_s = status_word(ovr_s, out_valid);

  always_comb begin
    io_read_data = {WIDTH{1'b0}};
    case (sel_s)
      SEL_PORT0: io_read_data = out_port0;
      SEL_PORT1: io_read_data = out_port1;
      SEL_PORT2: io_read_data = out_port2;
      SEL_STAT:  io_read_data = stat_s;
      default:   io_read_data = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_io_output_ctrl.sv
// Directed bench for io_output_ctrl: expectations are queued at stimulus time and
// popped when the corresponding output is sampled.
module tb_io_output_ctrl;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] out_port0, out_port1, out_port2;
  logic [2:0]  out_valid;
  logic [2:0]  out_ack;
  logic [31:0] io_read_data;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  io_output_ctrl dut (
    .io_clk(io_clk), .reset(reset), .addr(addr), .datain(datain),
    .write_io_enable(write_io_enable), .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .out_valid(out_valid), .out_ack(out_ack),
    .io_read_data(io_read_data)
  );

  always #5 io_clk = ~io_clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Inputs change on the falling edge and outputs are sampled there too.
  task automatic cycle();
    @(posedge io_clk);
    @(negedge io_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    datain = d;
    write_io_enable = 1'b1;
    cycle();
    write_io_enable = 1'b0;
    datain = 32'h0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    push(tag, exp);
    addr = a;
    #1;
    pop_check(io_read_data);
  endtask

  initial begin
    reset = 1'b1;
    addr = 32'h0;
    datain = 32'h0;
    write_io_enable = 1'b0;
    out_ack = 3'b000;
    @(negedge io_clk);
    cycle();
    reset = 1'b0;

    // 1. reset state
    rd_check("rst_rd80", 32'h80, 32'h0);
    rd_check("rst_rd84", 32'h84, 32'h0);
    rd_check("rst_rd88", 32'h88, 32'h0);
    rd_check("rst_rd8C", 32'h8C, 32'h0);
    push("rst_valid", 32'h0); pop_check({29'h0, out_valid});

    // 2. write port1, readback, ack
    push("p1_data", 32'h1234_5678);
    push("p1_valid", 32'h2);
    wr(32'h84, 32'h1234_5678);
    pop_check(out_port1);
    pop_check({29'h0, out_valid});
    rd_check("p1_rd84", 32'h84, 32'h1234_5678);
    push("p1_ack_valid", 32'h0);
    out_ack = 3'b010;
    cycle();
    out_ack = 3'b000;
    pop_check({29'h0, out_valid});

    // ack on an idle port is ignored
    push("idle_ack_valid", 32'h0);
    out_ack = 3'b001;
    cycle();
    out_ack = 3'b000;
    pop_check({29'h0, out_valid});

    // 3. overrun on port0, then clear it through status
    push("ovr_data", 32'hB);
    push("ovr_valid", 32'h1);
    wr(32'h80, 32'hA);
    wr(32'h80, 32'hB);
    pop_check(out_port0);
    pop_check({29'h0, out_valid});
    rd_check("ovr_stat", 32'h8C, 32'h9);
    wr(32'h8C, 32'h8);
    rd_check("ovr_clr_stat", 32'h8C, 32'h1);

    // 4. write with same-cycle ack on port2 is not an overrun
    wr(32'h88, 32'h5);
    push("wa_data", 32'hC);
    push("wa_valid", 32'h5);
    out_ack = 3'b100;
    wr(32'h88, 32'hC);
    out_ack = 3'b000;
    pop_check(out_port2);
    pop_check({29'h0, out_valid});
    rd_check("wa_stat", 32'h8C, 32'h5);

    // 5. reset wins over a simultaneous write to pending port0
    push("rstw_p0", 32'h0);
    push("rstw_p2", 32'h0);
    push("rstw_valid", 32'h0);
    reset = 1'b1;
    wr(32'h80, 32'hFF);
    reset = 1'b0;
    pop_check(out_port0);
    pop_check(out_port2);
    pop_check({29'h0, out_valid});
    rd_check("rstw_stat", 32'h8C, 32'h0);

    // 6. unmapped write changes nothing
    wr(32'h84, 32'h77);
    push("um_p1", 32'h77);
    push("um_p0", 32'h0);
    push("um_valid", 32'h2);
    wr(32'h90, 32'hDEAD);
    pop_check(out_port1);
    pop_check(out_port0);
    pop_check({29'h0, out_valid});
    rd_check("um_stat", 32'h8C, 32'h2);
    rd_check("um_rd90", 32'h90, 32'h0);

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_output_ctrl.md
Name: io_output_ctrl

Overview:
- Memory-mapped output-port block; the CPU-store counterpart of the input-port latch/mux block.
- Captures CPU store data into three 32-bit output port registers.
- Runs a valid/ack handshake per port to the external device and keeps sticky overrun flags.
- Exposes a readback path so the CPU can load port contents and handshake status.
- Sits on the same io address space as the input ports, decoded by addr[7:2].

Parameters:
- WIDTH, 32: data width of every port and of the bus.
- SEL_PORT0, 6'b100000: addr[7:2] value selecting out_port0 (byte address 0x80).
- SEL_PORT1, 6'b100001: addr[7:2] value selecting out_port1 (0x84).
- SEL_PORT2, 6'b100010: addr[7:2] value selecting out_port2 (0x88).
- SEL_STAT, 6'b100011: addr[7:2] value selecting the status register (0x8C).

Ports:
- io_clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the io_clk rising edge.
- addr  in  32  bus address; only addr[7:2] is decoded.
- datain  in  WIDTH  store data from the CPU.
- write_io_enable  in  1  store strobe, qualified by addr.
- out_port0 / out_port1 / out_port2  out  WIDTH each  registered port values.
- out_valid  out  3  bit i high means out_port i holds data not yet acknowledged.
- out_ack  in  3  device acknowledge, one bit per port.
- io_read_data  out  WIDTH  combinational readback selected by addr[7:2].

Behaviour:
- Reset (sync, when reset=1 at a clock edge):
  - out_port0..2 = 0.
  - out_valid = 3'b000.
  - Overrun flags = 0.
  - Reset overrides any simultaneous write or ack in that cycle.
- Port write (write_io_enable=1 and addr[7:2]==SEL_PORTi):
  - out_port i <= datain on the next edge; latency 1 cycle.
  - out_valid[i] <= 1.
- Ack:
  - out_ack[i]=1 while out_valid[i]=1 clears out_valid[i] on the next edge.
  - out_ack[i] while out_valid[i]=0 is ignored.
- Per-port handshake states, derived from valid: IDLE (valid=0) and PENDING (valid=1).
  - IDLE -> PENDING on write.
  - PENDING -> IDLE on ack with no write.
  - PENDING -> PENDING on write (with or without ack).
- Overrun:
  - A write to port i while out_valid[i]=1 and out_ack[i]=0 sets sticky ovr[i].
  - The new data still overwrites the port; valid stays 1.
- Simultaneous write and ack on the same port, same cycle:
  - The ack consumes the old data.
  - The new data loads, valid stays 1.
  - No overrun.
- Status register (SEL_STAT):
  - Read value = {26'b0, ovr[2:0], out_valid[2:0]}.
  - A write with datain[3+i]=1 clears ovr[i]; other bits are ignored.
  - If a clear and a new overrun event occur in the same cycle for the same port, the set wins (ovr stays 1).
- Writes to unmapped selects have no effect.
- io_read_data:
  - Purely combinational mux on addr[7:2].
  - Ports return their register values; SEL_STAT returns status; all other selects return 0.
  - Readback shows pre-edge values; a write is visible one cycle later.
- Only one write per cycle is possible (single bus), so there are no write-write conflicts.

Decomposition:
- Shared io package holds:
  - Address select constants (SEL_PORT*, SEL_STAT) so they stay consistent with the input-side selects (0xC0/0xC4).
  - Status bit positions (VALID_LSB=0, OVR_LSB=3).
- One sub-module is natural: io_out_port, one instance per port.
  - Contents: port register, valid bit, overrun bit, handshake logic.
  - Interface: wr, clr_ovr, ack, din; outputs dout, valid, ovr.
- The readback mux stays inline; it is small enough, and it mirrors the existing input mux.

Test Plan:
1. Reset, then read 0x80, 0x84, 0x88 and 0x8C -> all 0; out_valid=000.
2. Write 0x12345678 to 0x84 -> next cycle out_port1=0x12345678 and out_valid=010; readback at 0x84 = 0x12345678; then ack[1] -> next cycle out_valid=000.
3. Write 0xA to 0x80, then write 0xB to 0x80 with no ack -> out_port0=0xB, valid[0]=1, status=0x009; write 0x8 to 0x8C -> status=0x001.
4. Write 0xC to 0x88 while valid[2]=1 and ack[2]=1 in the same cycle -> out_port2=0xC, valid[2]=1, ovr[2]=0.
5. Assert reset in the same cycle as a write of 0xFF to 0x80 with port 0 pending -> out_port0=0, valid=000, ovr=000.
6. Write 0xDEAD to 0x90 (unmapped) -> no port or status change; readback at 0x90 = 0.
